// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Count width helper and op-decode enumeration used by RTL and bench.
package lifo_stack_pkg;

  localparam int DEPTH_DEFAULT = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEPTH_DEFAULT);

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  // Push+Pop on an empty stack degenerates to a plain push.
  function automatic op_e decode_op(input logic push, input logic pop, input logic empty);
    op_e op;
    op = OP_NONE;
    if (push && pop)  op = empty ? OP_PUSH : OP_REPLACE;
    else if (push)    op = OP_PUSH;
    else if (pop)     op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/lifo_stack_param_if.sv
// Request/response bundle of the LIFO stack; master drives requests,
// slave (the stack) drives top-of-stack, occupancy and flags.
interface lifo_stack_param_if
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);

  localparam int CW = cnt_w(DEPTH);

  logic             Enable;
  logic             Push;
  logic             Pop;
  logic             ClrErr;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] O;
  logic [CW-1:0]    Count;
  logic             Empty;
  logic             Full;
  logic             AlmostFull;
  logic             Overflow;
  logic             Underflow;

  modport master (
    output Enable, Push, Pop, ClrErr, I,
    input  O, Count, Empty, Full, AlmostFull, Overflow, Underflow
  );

  modport slave (
    input  Enable, Push, Pop, ClrErr, I,
    output O, Count, Empty, Full, AlmostFull, Overflow, Underflow
  );

endinterface

// File: rtl/lifo_stack_ram.sv
// DEPTH x WIDTH stack storage: one synchronous write port and two
// asynchronous read ports (used for the entries at sp-1 and sp-2).
module lifo_stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Pointer arithmetic below zero yields addresses past DEPTH for
  // non-power-of-2 depths; those reads are don't-care, return zero.
  assign rdata_a = (int'(raddr_a) < DEPTH) ? mem[raddr_a] : '0;
  assign rdata_b = (int'(raddr_b) < DEPTH) ? mem[raddr_b] : '0;

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with registered top-of-stack and occupancy flags.
// Optional sticky Overflow/Underflow registers built when LIFO_STACK_ERR_EN is defined.
module lifo_stack_param
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic               CLK,
  input logic               Reset_n,
  lifo_stack_param_if.slave s
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] SP_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] SP_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] SP_ONE  = CW'(1);
  localparam logic [CW-1:0] SP_TWO  = CW'(2);

  logic [CW-1:0]    sp, sp_nxt, sp_m1, sp_m2, wptr;
  logic [WIDTH-1:0] o_q, o_nxt, rd_a, rd_b;
  logic             empty, full, we_req, ovf_set, unf_set;
  op_e              op;

  assign empty = (sp == '0);
  assign full  = (sp == SP_FULL);
  assign sp_m1 = sp - SP_ONE;
  assign sp_m2 = sp - SP_TWO;
  assign op    = decode_op(s.Push, s.Pop, empty);

  always_comb begin
    sp_nxt  = sp;
    o_nxt   = o_q;
    we_req  = 1'b0;
    wptr    = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we_req = 1'b1;
          sp_nxt = sp + SP_ONE;
          o_nxt  = s.I;
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          sp_nxt = sp_m1;
          o_nxt  = (sp >= SP_TWO) ? rd_b : '0;
        end
      end
      OP_REPLACE: begin
        we_req = 1'b1;
        wptr   = sp_m1;
        o_nxt  = s.I;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sp  <= '0;
      o_q <= '0;
    end else if (s.Enable) begin
      sp  <= sp_nxt;
      o_q <= o_nxt;
    end
  end

  lifo_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (CLK),
    .we      (s.Enable & we_req),
    .waddr   (wptr[AW-1:0]),
    .wdata   (s.I),
    .raddr_a (sp_m1[AW-1:0]),
    .rdata_a (rd_a),
    .raddr_b (sp_m2[AW-1:0]),
    .rdata_b (rd_b)
  );

  assign s.O          = o_q;
  assign s.Count      = sp;
  assign s.Empty      = empty;
  assign s.Full       = full;
  assign s.AlmostFull = (sp >= SP_AF);

`ifdef LIFO_STACK_ERR_EN
  logic ovf_q, unf_q;

  // A fresh error on the clearing edge takes priority over ClrErr.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (s.Enable) begin
      if (ovf_set)       ovf_q <= 1'b1;
      else if (s.ClrErr) ovf_q <= 1'b0;
      if (unf_set)       unf_q <= 1'b1;
      else if (s.ClrErr) unf_q <= 1'b0;
    end
  end

  assign s.Overflow  = ovf_q;
  assign s.Underflow = unf_q;

  logic unused_rd;
  assign unused_rd = ^rd_a;
`else
  assign s.Overflow  = 1'b0;
  assign s.Underflow = 1'b0;

  logic unused_err;
  assign unused_err = ^{rd_a, s.ClrErr, ovf_set, unf_set};
`endif

endmodule
